// File: rtl/slicer_16_qam_ref.sv
// 16-QAM receive slicer: Gray-coded decisions, per-axis decision error and a
// block-mean estimate of |I| that sets the decision thresholds.
module slicer_16_qam_ref #(
  parameter int unsigned       LOG2_AVG = 10,
  parameter logic signed [17:0] REF_INIT = 18'sd65536
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic signed [17:0] sig_inph,
  input  logic signed [17:0] sig_quad,
  input  logic               ref_hold,
  output logic [3:0]         data,
  output logic               data_valid,
  output logic signed [18:0] err_inph,
  output logic signed [18:0] err_quad,
  output logic signed [17:0] ref_level_est,
  output logic               ref_valid
);

  localparam int unsigned ACC_W = 18 + LOG2_AVG;

  // Decide one axis against levels +-r/2 and +-3r/2; returns {symbol, error}.
  function automatic logic [20:0] slice_axis(input logic signed [17:0] x,
                                             input logic signed [17:0] r);
    logic signed [18:0] xs;
    logic signed [18:0] rs;
    logic signed [18:0] hs;
    logic signed [18:0] lvl;
    logic [1:0]         sym;
    xs = {x[17], x};
    rs = {r[17], r};
    hs = {2'b00, r[17:1]};
    if (xs >= rs) begin
      sym = 2'b00;
      lvl = rs + hs;
    end else if (xs >= 19'sd0) begin
      sym = 2'b01;
      lvl = hs;
    end else if (xs >= -rs) begin
      sym = 2'b11;
      lvl = -hs;
    end else begin
      sym = 2'b10;
      lvl = -(rs + hs);
    end
    return {sym, 19'(xs - lvl)};
  endfunction

  logic [3:0]          data_q, data_d;
  logic                data_valid_q, data_valid_d;
  logic signed [18:0]  err_inph_q, err_inph_d;
  logic signed [18:0]  err_quad_q, err_quad_d;
  logic signed [17:0]  ref_q, ref_d;
  logic                ref_valid_q, ref_valid_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [LOG2_AVG-1:0] cnt_q, cnt_d;

  logic [20:0]      res_i;
  logic [20:0]      res_q;
  logic [17:0]      abs_i;
  logic [ACC_W-1:0] acc_sum;
  logic [17:0]      ref_new;

  always_comb begin
    res_i = slice_axis(sig_inph, ref_q);
    res_q = slice_axis(sig_quad, ref_q);

    // Saturating magnitude so the most negative sample does not wrap.
    if (sig_inph == 18'sh20000) begin
      abs_i = 18'h1FFFF;
    end else if (sig_inph[17]) begin
      abs_i = 18'(-sig_inph);
    end else begin
      abs_i = sig_inph;
    end
    acc_sum = acc_q + ACC_W'(abs_i);
    ref_new = 18'(acc_sum >> LOG2_AVG);

    data_d       = data_q;
    data_valid_d = 1'b0;
    err_inph_d   = err_inph_q;
    err_quad_d   = err_quad_q;
    ref_d        = ref_q;
    ref_valid_d  = 1'b0;
    acc_d        = acc_q;
    cnt_d        = cnt_q;

    if (clk_en) begin
      data_d       = {res_q[20:19], res_i[20:19]};
      err_inph_d   = res_i[18:0];
      err_quad_d   = res_q[18:0];
      data_valid_d = 1'b1;
    end

    if (ref_hold) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (clk_en) begin
      if (cnt_q == '1) begin
        acc_d       = '0;
        cnt_d       = '0;
        ref_valid_d = 1'b1;
        // A zero mean would collapse all thresholds; keep the old level.
        if (ref_new != 18'd0) begin
          ref_d = ref_new;
        end
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + LOG2_AVG'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
      err_inph_q   <= '0;
      err_quad_q   <= '0;
      ref_q        <= REF_INIT;
      ref_valid_q  <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
    end else begin
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      err_inph_q   <= err_inph_d;
      err_quad_q   <= err_quad_d;
      ref_q        <= ref_d;
      ref_valid_q  <= ref_valid_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
    end
  end

  assign data          = data_q;
  assign data_valid    = data_valid_q;
  assign err_inph      = err_inph_q;
  assign err_quad      = err_quad_q;
  assign ref_level_est = ref_q;
  assign ref_valid     = ref_valid_q;

endmodule

// File: tb/tb_slicer_16_qam_ref.sv
// Directed bench for slicer_16_qam_ref with a 16-symbol estimate block.
module tb_slicer_16_qam_ref;

  logic               clk;
  logic               reset;
  logic               clk_en;
  logic signed [17:0] sig_inph;
  logic signed [17:0] sig_quad;
  logic               ref_hold;
  logic [3:0]         data;
  logic               data_valid;
  logic signed [18:0] err_inph;
  logic signed [18:0] err_quad;
  logic signed [17:0] ref_level_est;
  logic               ref_valid;

  int n_checks;
  int n_fail;

  typedef struct {
    int i;
    int q;
    int data;
    int ei;
    int eq;
  } vec_t;

  vec_t vecs[9];

  slicer_16_qam_ref #(
    .LOG2_AVG(4),
    .REF_INIT(18'sd65536)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .sig_inph     (sig_inph),
    .sig_quad     (sig_quad),
    .ref_hold     (ref_hold),
    .data         (data),
    .data_valid   (data_valid),
    .err_inph     (err_inph),
    .err_quad     (err_quad),
    .ref_level_est(ref_level_est),
    .ref_valid    (ref_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One strobe; returns #1 after the capturing edge.
  task automatic strobe(input int i, input int q, input logic hold);
    @(negedge clk);
    sig_inph = 18'(i);
    sig_quad = 18'(q);
    ref_hold = hold;
    clk_en   = 1'b1;
    @(posedge clk);
    #1;
    clk_en   = 1'b0;
    ref_hold = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    clk_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One-cycle reset with a strobe pending to show reset wins.
  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    clk_en   = 1'b1;
    ref_hold = 1'b0;
    sig_inph = 18'sd1000;
    sig_quad = 18'sd1000;
    @(negedge clk);
    reset  = 1'b0;
    clk_en = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clk_en   = 1'b0;
    ref_hold = 1'b0;
    sig_inph = '0;
    sig_quad = '0;

    // r = 65536: P2 = 98304, P1 = 32768
    vecs[0] = '{i:  98304, q: -32768, data: 4'b1100, ei:      0, eq:      0};
    vecs[1] = '{i:  65536, q:  98304, data: 4'b0000, ei: -32768, eq:      0};
    vecs[2] = '{i:  65535, q:  98304, data: 4'b0001, ei:  32767, eq:      0};
    vecs[3] = '{i:      0, q:  98304, data: 4'b0001, ei: -32768, eq:      0};
    vecs[4] = '{i:     -1, q:  98304, data: 4'b0011, ei:  32767, eq:      0};
    vecs[5] = '{i: -65536, q:  98304, data: 4'b0011, ei: -32768, eq:      0};
    vecs[6] = '{i: -65537, q:  98304, data: 4'b0010, ei:  32767, eq:      0};
    vecs[7] = '{i: 131071, q:-131072, data: 4'b1000, ei:  32767, eq: -32768};
    vecs[8] = '{i:  10000, q: -10000, data: 4'b1101, ei: -22768, eq:  22768};

    repeat (2) @(negedge clk);
    do_reset();
    chk("rst_data", int'(data), 0);
    chk("rst_dv", int'(data_valid), 0);
    chk("rst_ei", int'(err_inph), 0);
    chk("rst_eq", int'(err_quad), 0);
    chk("rst_ref", int'(ref_level_est), 65536);
    chk("rst_rv", int'(ref_valid), 0);

    // Table of slicing vectors with the estimate frozen.
    for (int k = 0; k < 9; k++) begin
      strobe(vecs[k].i, vecs[k].q, 1'b1);
      chk("vec_dv", int'(data_valid), 1);
      chk("vec_data", int'(data), vecs[k].data);
      chk("vec_ei", int'(err_inph), vecs[k].ei);
      chk("vec_eq", int'(err_quad), vecs[k].eq);
      chk("vec_rv", int'(ref_valid), 0);
    end
    idle();
    chk("idle_dv", int'(data_valid), 0);
    chk("idle_data", int'(data), vecs[8].data);
    chk("hold_ref", int'(ref_level_est), 65536);

    // Block mean of alternating +60000 / -20000 = 40000.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      strobe((k % 2 == 0) ? 60000 : -20000, 0, 1'b0);
      chk("blk_dv", int'(data_valid), 1);
      chk("blk_rv", int'(ref_valid), (k == 15) ? 1 : 0);
      chk("blk_ref", int'(ref_level_est), (k == 15) ? 40000 : 65536);
      if (k == 15) begin
        chk("blk_last_sym", int'(data[1:0]), 3);
        chk("blk_last_ei", int'(err_inph), 12768);
        chk("blk_last_eq", int'(err_quad), -32768);
      end
    end
    idle();
    chk("blk_rv_drop", int'(ref_valid), 0);
    strobe(40000, 0, 1'b0);
    chk("new_thr_hi", int'(data[1:0]), 0);
    chk("new_thr_hi_ei", int'(err_inph), -20000);
    strobe(39999, 0, 1'b0);
    chk("new_thr_lo", int'(data[1:0]), 1);
    chk("new_thr_lo_ei", int'(err_inph), 19999);

    // Most negative input saturates |I| to 131071.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      strobe(-131072, 0, 1'b0);
      chk("sat_sym", int'(data[1:0]), 2);
      chk("sat_rv", int'(ref_valid), (k == 15) ? 1 : 0);
    end
    chk("sat_ref", int'(ref_level_est), 131071);

    // Reset mid-block discards the partial accumulation.
    do_reset();
    for (int k = 0; k < 7; k++) strobe(100000, 0, 1'b0);
    do_reset();
    chk("mid_rst_ref", int'(ref_level_est), 65536);
    chk("mid_rst_dv", int'(data_valid), 0);
    for (int k = 0; k < 16; k++) begin
      strobe((k % 2 == 0) ? 50000 : -50000, 0, 1'b0);
      chk("rstblk_rv", int'(ref_valid), (k == 15) ? 1 : 0);
      chk("rstblk_ref", int'(ref_level_est), (k == 15) ? 50000 : 65536);
    end

    // ref_hold mid-block restarts the block; slicing continues (r = 50000).
    for (int k = 0; k < 7; k++) strobe(10000, 0, 1'b0);
    strobe(10000, 0, 1'b1);
    chk("hold_rv", int'(ref_valid), 0);
    chk("hold_dv", int'(data_valid), 1);
    chk("hold_sym", int'(data[1:0]), 1);
    chk("hold_ei", int'(err_inph), -15000);
    for (int k = 0; k < 16; k++) begin
      strobe((k % 2 == 0) ? -30000 : 30000, 0, 1'b0);
      chk("holdblk_rv", int'(ref_valid), (k == 15) ? 1 : 0);
      chk("holdblk_ref", int'(ref_level_est), (k == 15) ? 30000 : 50000);
    end

    // Gapped strobes, r = 30000: I=60000 -> 00 err 15000, Q=0 -> 01 err -15000.
    for (int k = 0; k < 16; k++) begin
      strobe(60000, 0, 1'b0);
      chk("gap_dv", int'(data_valid), 1);
      chk("gap_data", int'(data), 4'b0100);
      chk("gap_ei", int'(err_inph), 15000);
      chk("gap_eq", int'(err_quad), -15000);
      chk("gap_rv", int'(ref_valid), (k == 15) ? 1 : 0);
      for (int g = 0; g < 3; g++) begin
        idle();
        chk("gap_idle_dv", int'(data_valid), 0);
        chk("gap_idle_data", int'(data), 4'b0100);
        chk("gap_idle_ei", int'(err_inph), 15000);
        chk("gap_idle_rv", int'(ref_valid), 0);
      end
    end
    chk("gap_ref", int'(ref_level_est), 60000);

    // All-zero block: estimate kept, pulse still issued (r = 60000, h = 30000).
    for (int k = 0; k < 16; k++) begin
      strobe(0, 0, 1'b0);
      chk("zero_data", int'(data), 4'b0101);
      chk("zero_ei", int'(err_inph), -30000);
      chk("zero_rv", int'(ref_valid), (k == 15) ? 1 : 0);
    end
    chk("zero_ref", int'(ref_level_est), 60000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
